// File: rtl/axis_crosspoint_sched.sv
// Route scheduler for an AXI-Stream crosspoint: per-output select changes commit only on packet boundaries.
// Optional forced-switch timeout is built when AXIS_XP_SCHED_TIMEOUT_EN is defined.
//
// state   | meaning
// ST_IDLE | no request outstanding for this output
// ST_WAIT | request accepted, waiting until old and new inputs are both between packets
module axis_crosspoint_sched #(
  parameter int S_COUNT        = 4,
  parameter int M_COUNT        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CL_S = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  localparam int CL_M = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_COUNT-1:0]      s_axis_tvalid,
  input  logic [S_COUNT-1:0]      s_axis_tlast,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CL_M-1:0]         cfg_port,
  input  logic [CL_S-1:0]         cfg_select,
  output logic [M_COUNT*CL_S-1:0] select,
  output logic [M_COUNT-1:0]      pending,
  output logic [M_COUNT-1:0]      cfg_done,
  output logic                    cfg_err,
  output logic [M_COUNT-1:0]      timeout_flag
);

  if (S_COUNT < 2 || M_COUNT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axis_crosspoint_sched: illegal parameter value");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              r_state     [M_COUNT];
  state_t              w_state_nxt [M_COUNT];
  logic [CL_S-1:0]     r_sel       [M_COUNT];
  logic [CL_S-1:0]     r_req_sel   [M_COUNT];
  logic [S_COUNT-1:0]  r_in_pkt;
  logic [S_COUNT-1:0]  w_in_pkt_nxt;
  logic [M_COUNT-1:0]  r_done;
  logic                r_err;

  logic                w_port_ok;
  logic                w_sel_ok;
  logic                w_cfg_ok;
  logic                w_accept;
  logic [M_COUNT-1:0]  w_port_dec;
  logic [M_COUNT-1:0]  w_req_set;
  logic [M_COUNT-1:0]  w_pending;
  logic [M_COUNT-1:0]  w_safe;
  logic [M_COUNT-1:0]  w_force;
  logic [M_COUNT-1:0]  w_commit;

  // An input is mid-packet after a non-last beat until its last beat has been seen.
  assign w_in_pkt_nxt = (s_axis_tvalid & ~s_axis_tlast) | (~s_axis_tvalid & r_in_pkt);

  assign w_port_ok  = ({1'b0, cfg_port} < (CL_M+1)'(M_COUNT));
  assign w_sel_ok   = ({1'b0, cfg_select} < (CL_S+1)'(S_COUNT));
  assign w_cfg_ok   = w_port_ok & w_sel_ok;
  assign cfg_ready  = w_port_ok ? ~w_pending[cfg_port] : 1'b1;
  assign w_accept   = cfg_valid & cfg_ready;
  assign w_port_dec = M_COUNT'(1) << cfg_port;
  assign w_req_set  = (w_accept & w_cfg_ok) ? w_port_dec : '0;

  for (genvar m = 0; m < M_COUNT; m++) begin : g_out
    assign w_pending[m]               = (r_state[m] == ST_WAIT);
    assign w_safe[m]                  = ~w_in_pkt_nxt[r_sel[m]] & ~w_in_pkt_nxt[r_req_sel[m]];
    assign select[m*CL_S +: CL_S]     = r_sel[m];
  end

  always_comb begin
    w_commit = '0;
    for (int m = 0; m < M_COUNT; m++) begin
      w_state_nxt[m] = r_state[m];
      case (r_state[m])
        ST_IDLE: if (w_req_set[m]) w_state_nxt[m] = ST_WAIT;
        ST_WAIT: begin
          if (w_safe[m] | w_force[m]) begin
            w_state_nxt[m] = ST_IDLE;
            w_commit[m]    = 1'b1;
          end
        end
        default: w_state_nxt[m] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pkt <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      for (int m = 0; m < M_COUNT; m++) begin
        r_state[m]   <= ST_IDLE;
        r_sel[m]     <= '0;
        r_req_sel[m] <= '0;
      end
    end else begin
      r_in_pkt <= w_in_pkt_nxt;
      r_done   <= w_commit;
      r_err    <= w_accept & ~w_cfg_ok;
      for (int m = 0; m < M_COUNT; m++) begin
        r_state[m] <= w_state_nxt[m];
        if (w_req_set[m]) r_req_sel[m] <= cfg_select;
        if (w_commit[m])  r_sel[m]     <= r_req_sel[m];
      end
    end
  end

  assign pending  = w_pending;
  assign cfg_done = r_done;
  assign cfg_err  = r_err;

`ifdef AXIS_XP_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0]      r_tmr [M_COUNT];
  logic [M_COUNT-1:0] r_tflag;

  // Down-counter loaded on accept; terminal count in WAIT forces the switch.
  for (genvar m = 0; m < M_COUNT; m++) begin : g_tmo
    assign w_force[m] = (r_state[m] == ST_WAIT) && (r_tmr[m] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tflag <= '0;
      for (int m = 0; m < M_COUNT; m++) r_tmr[m] <= '0;
    end else begin
      for (int m = 0; m < M_COUNT; m++) begin
        if (w_req_set[m])
          r_tmr[m] <= TW'(TIMEOUT_CYCLES - 1);
        else if (r_state[m] == ST_WAIT && r_tmr[m] != '0)
          r_tmr[m] <= r_tmr[m] - 1'b1;
        if (w_force[m]) r_tflag[m] <= 1'b1;
      end
    end
  end

  assign timeout_flag = r_tflag;
`else
  assign w_force      = '0;
  assign timeout_flag = '0;
`endif

endmodule
